// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port used by the fetch unit.
//
// Handshake: the master raises imem_req with imem_addr and keeps both stable
// until a transfer happens; a transfer is any rising clock edge at which
// imem_req && imem_ack are both high. imem_rdata is only meaningful while
// imem_ack is high. At most one request is outstanding at a time. The master
// may drop imem_req without a transfer only when it is reset.
interface if_fetch_unit_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32
) ();

    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    // Fetch unit side: drives the request, receives the response.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: observes the request, drives the response.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface : if_fetch_unit_if

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage.
//
// Owns the program counter and keeps one read request in flight to the
// instruction memory. Each fetched word is presented to the IF/ID register
// together with its address + 1 (outPC). A downstream stall is absorbed by a
// one-entry skid buffer so a read that completes while the output is held is
// never lost. A redirect pulse from a later stage flushes the output and
// restarts fetching at the new target; a read already in flight is allowed to
// finish and its data is thrown away.
//
// FSM:
//   IDLE     - one cycle after reset, no request.
//   FETCH    - request for r_req_addr outstanding.
//   BUFFERED - a fetched word waits in the skid buffer behind a held output.
//   SQUASH   - request for a pre-redirect address outstanding; its data is
//              discarded and fetching resumes at r_pc (the redirect target).
module if_fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    if_fetch_unit_if.master        imem,
    output logic [PC_WIDTH-1:0]    outPC,
    output logic [INSTR_WIDTH-1:0] outInstruction,
    output logic                   outValid,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_BUFFERED = 2'd2,
        S_SQUASH   = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [PC_WIDTH-1:0]    r_pc;          // next address to fetch after the current one
    logic [PC_WIDTH-1:0]    r_req_addr;    // address on the memory port
    logic [INSTR_WIDTH-1:0] r_buf_instr;   // skid buffer: word
    logic [PC_WIDTH-1:0]    r_buf_pc;      // skid buffer: its address + 1
    logic [PC_WIDTH-1:0]    r_out_pc;
    logic [INSTR_WIDTH-1:0] r_out_instr;
    logic                   r_out_valid;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                 w_state_nxt;
    logic [PC_WIDTH-1:0]    w_pc_nxt;
    logic [PC_WIDTH-1:0]    w_req_addr_nxt;
    logic [INSTR_WIDTH-1:0] w_buf_instr_nxt;
    logic [PC_WIDTH-1:0]    w_buf_pc_nxt;
    logic [PC_WIDTH-1:0]    w_out_pc_nxt;
    logic [INSTR_WIDTH-1:0] w_out_instr_nxt;
    logic                   w_out_valid_nxt;

    logic                   w_ack;
    logic                   w_out_held;
    logic [PC_WIDTH-1:0]    w_req_inc;

    assign w_ack      = imem.imem_ack;
    // The output slot is occupied and the consumer refuses it this cycle.
    assign w_out_held = stall && r_out_valid;
    // Address + 1 wraps naturally at 2^PC_WIDTH.
    assign w_req_inc  = r_req_addr + PC_ONE;

    // The request is a pure function of state, so it drops the instant the
    // asynchronous reset forces the FSM to IDLE.
    assign imem.imem_req  = (r_state == S_FETCH) || (r_state == S_SQUASH);
    assign imem.imem_addr = r_req_addr;

    assign outPC          = r_out_pc;
    assign outInstruction = r_out_instr;
    assign outValid       = r_out_valid;
    assign o_dbg_state    = r_state;

    // Next-state and datapath update logic; redirect takes priority over stall and ack.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_req_addr_nxt  = r_req_addr;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;
        w_out_pc_nxt    = r_out_pc;
        w_out_instr_nxt = r_out_instr;
        w_out_valid_nxt = r_out_valid;

        if (redirect) begin
            // Flush whatever the output or skid buffer holds; new stream
            // starts at the target.
            w_pc_nxt        = redirect_target;
            w_out_pc_nxt    = '0;
            w_out_instr_nxt = '0;
            w_out_valid_nxt = 1'b0;

            case (r_state)
                S_IDLE, S_BUFFERED: begin
                    // No request outstanding, so the port may move at once.
                    w_req_addr_nxt = redirect_target;
                    w_state_nxt    = S_FETCH;
                end
                S_FETCH: begin
                    if (w_ack) begin
                        // Read completes now; drop its data and aim at target.
                        w_req_addr_nxt = redirect_target;
                        w_state_nxt    = S_FETCH;
                    end else begin
                        // Address must stay put until the memory answers.
                        w_state_nxt = S_SQUASH;
                    end
                end
                S_SQUASH: begin
                    if (w_ack) begin
                        // Stale read finishes in the same cycle as a newer
                        // redirect: go straight to the newest target.
                        w_req_addr_nxt = redirect_target;
                        w_state_nxt    = S_FETCH;
                    end else begin
                        w_state_nxt = S_SQUASH;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_req_addr_nxt = r_pc;
                    w_state_nxt    = S_FETCH;
                end

                S_FETCH: begin
                    if (w_ack) begin
                        if (!w_out_held) begin
                            // Output slot free (or being consumed): deliver
                            // directly, zero cycles after the ack edge.
                            w_out_instr_nxt = imem.imem_rdata;
                            w_out_pc_nxt    = w_req_inc;
                            w_out_valid_nxt = 1'b1;
                            w_pc_nxt        = w_req_inc;
                            w_req_addr_nxt  = w_req_inc;
                        end else begin
                            // Output is frozen: park the word and stop
                            // requesting until the consumer drains.
                            w_buf_instr_nxt = imem.imem_rdata;
                            w_buf_pc_nxt    = w_req_inc;
                            w_pc_nxt        = w_req_inc;
                            w_state_nxt     = S_BUFFERED;
                        end
                    end else if (!stall) begin
                        // Current output consumed with nothing to replace it.
                        w_out_valid_nxt = 1'b0;
                    end
                end

                S_BUFFERED: begin
                    if (!stall) begin
                        w_out_instr_nxt = r_buf_instr;
                        w_out_pc_nxt    = r_buf_pc;
                        w_out_valid_nxt = 1'b1;
                        w_req_addr_nxt  = r_pc;
                        w_state_nxt     = S_FETCH;
                    end
                end

                S_SQUASH: begin
                    if (w_ack) begin
                        // Stale data is ignored; restart at the redirect target.
                        w_req_addr_nxt = r_pc;
                        w_state_nxt    = S_FETCH;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule : if_fetch_unit

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates wait states.
- Delivers fetched words with the incremented PC to the IF/ID pipeline register. The IF/ID register recovers the instruction address by subtracting 1 from outPC.
- Supports a downstream stall, via a one-entry skid buffer, and a branch redirect/flush from later stages.

Parameters:
PC_WIDTH, 8, width of PC and instruction address
INSTR_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset (asserted at 0)
stall  in  1  downstream cannot accept; hold outputs
redirect  in  1  branch taken/flush request, 1-cycle pulse
redirect_target  in  PC_WIDTH  new fetch address when redirect=1
imem_req  out  1  read request to instruction memory
imem_addr  out  PC_WIDTH  read address; stable while imem_req=1
imem_ack  in  1  memory response; transfer on posedge where imem_req&&imem_ack
imem_rdata  in  INSTR_WIDTH  read data; valid when imem_ack=1
outPC  out  PC_WIDTH  address of delivered instruction + 1, mod 2^PC_WIDTH
outInstruction  out  INSTR_WIDTH  delivered instruction
outValid  out  1  outPC/outInstruction hold a live instruction

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, req_addr=RESET_PC, state=IDLE, skid buffer empty.
  - outPC=0, outInstruction=0, outValid=0; imem_req=0 for the whole time rst=0.
- imem_req is high in FETCH and SQUASH only. imem_addr=req_addr, a register that changes only when no request is outstanding. One outstanding request maximum.
- States:
  - IDLE: next cycle -> FETCH with req_addr=pc.
  - FETCH, ack and no redirect:
    - If !(stall && outValid): outInstruction<=imem_rdata, outPC<=req_addr+1, outValid<=1. pc and req_addr <= req_addr+1. Stay FETCH.
    - Else: buffer <= {rdata, req_addr+1}, pc<=req_addr+1 -> BUFFERED.
  - FETCH, no ack:
    - Hold request.
    - If !stall, outValid<=0 (bubble consumed).
  - BUFFERED:
    - imem_req=0.
    - When !stall: outputs <= buffer, outValid=1, req_addr<=pc -> FETCH.
  - SQUASH:
    - Request for the old req_addr stays asserted until ack. The ack data is discarded.
    - Then req_addr<=pc (the redirect target) -> FETCH.
- Throughput: 1 instruction/cycle when ack is held high and stall=0. Latency from ack edge to outValid=1 is 0 cycles (data registered on the ack edge).
- Stall (stall=1, outValid=1, no redirect): outputs hold exactly. A new fetch may complete into the skid buffer only; no data is lost or duplicated.
- Redirect (highest priority, beats stall and ack):
  - pc<=redirect_target, outValid<=0, outInstruction<=0, outPC<=0, skid buffer invalidated.
  - If in FETCH with no ack this cycle -> SQUASH.
  - If ack this cycle -> data discarded, req_addr<=redirect_target, stay FETCH.
  - From BUFFERED or IDLE -> FETCH at target.
  - Redirect during SQUASH: pc<=new target; stay SQUASH.
- Wrap-around: pc 0xFF+1 = 0x00. outPC for an instruction at 0xFF is 0x00.
- Reset mid-request: all state cleared immediately. The memory must tolerate the request being dropped (imem_req falls asynchronously).

Test Plan:
- Reset release, ack tied 1, stall=0 -> imem_addr 0,1,2,... on consecutive cycles; outPC 1,2,3 with outValid=1 from the first ack edge; rdata passed to outInstruction unchanged.
- Ack delayed 3 cycles per request -> imem_addr held stable for the full wait, with outValid=0 between deliveries. Each word delivered exactly once, with correct outPC.
- Stall held 4 cycles while ack=1, on outPC=5 -> outputs frozen at outPC=5. Next word (addr 5) held in the buffer with imem_req=0. On release, outPC=6 then 7; no gap in sequence, no duplicates.
- Redirect to 0x40 while a request for 0x10 is waiting on ack -> outValid=0 immediately and imem_addr stays 0x10 until ack; that data is dropped. Next request is addr 0x40, delivering outPC=0x41.
- Redirect to 0xFF, same cycle as ack -> ack data dropped; next fetch at 0xFF; delivered outPC=0x00, next imem_addr=0x00.
- rst pulled low mid-wait at addr 0x22 -> imem_req=0 and outValid=0 asynchronously. After release, IDLE for 1 cycle, then fetch restarts at RESET_PC.
